// File: rtl/cv32e40p_irq_arbiter.sv
// Interrupt arbiter feeding the CV32E40P irq_i bus: pending/enable registers, one-at-a-time grant, ack retire.
// Optional watchdog and BACKOFF state are built only when CV32E40P_IRQ_TIMEOUT_EN is defined.
module cv32e40p_irq_arbiter #(
  parameter logic [31:0] VALID_MASK     = 32'hFFFF_0888,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [31:0]      src_irq_i,
  input  logic             cfg_we_i,
  input  logic [31:0]      cfg_en_i,
  input  logic             irq_ack_i,
  input  logic [4:0]       irq_id_i,
  output logic [31:0]      irq_o,
  output logic [31:0]      pending_o,
  output logic [31:0]      enable_o,
  output logic             busy_o,
  output logic             spurious_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  // state   | meaning
  // IDLE    | no interrupt presented, arbitrate candidates
  // ASSERT  | one interrupt presented, waiting for its ack
  // BACKOFF | one quiet cycle after a watchdog withdrawal
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] BACKOFF = 2'd2;

  logic [1:0]  state;
  logic [31:0] pending;
  logic [31:0] enable;
  logic [4:0]  grant_id;
  logic [31:0] cand;
  logic [31:0] clr;
  logic [31:0] pending_nxt;
  logic [4:0]  winner;
  logic        ack_match;
  logic        wd_expire;

  assign cand      = pending & enable;
  assign ack_match = (state == ASSERT) && irq_ack_i && (irq_id_i == grant_id);
  assign clr       = ack_match ? (32'd1 << grant_id) : 32'd0;
  // A new request in the same cycle as its clear keeps the bit pending.
  assign pending_nxt = (pending & ~clr) | (src_irq_i & VALID_MASK);

  // Lowest priority assigned first so that later, higher-priority hits override it.
  always_comb begin
    winner = 5'd0;
    if (cand[7])  winner = 5'd7;
    if (cand[3])  winner = 5'd3;
    if (cand[11]) winner = 5'd11;
    for (int i = 16; i < 32; i++) begin
      if (cand[i]) winner = 5'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 32'd0;
      enable     <= 32'd0;
      grant_id   <= 5'd0;
      irq_o      <= 32'd0;
      spurious_o <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      spurious_o <= irq_ack_i && !ack_match;
      if (cfg_we_i) enable <= cfg_en_i & VALID_MASK;
      case (state)
        IDLE: begin
          if (|cand) begin
            grant_id <= winner;
            irq_o    <= 32'd1 << winner;
            state    <= ASSERT;
          end else begin
            irq_o <= 32'd0;
          end
        end
        ASSERT: begin
          if (ack_match || !enable[grant_id]) begin
            irq_o <= 32'd0;
            state <= IDLE;
          end else if (wd_expire) begin
            irq_o <= 32'd0;
            state <= BACKOFF;
          end
        end
        BACKOFF: begin
          irq_o <= 32'd0;
          state <= IDLE;
        end
        default: begin
          irq_o <= 32'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign pending_o = pending;
  assign enable_o  = enable;
  assign busy_o    = (state == ASSERT);

`ifdef CV32E40P_IRQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog;
  logic            wd_run;

  // Watchdog only counts while the grant is still live (no ack, not withdrawn).
  assign wd_run    = (state == ASSERT) && !ack_match && enable[grant_id];
  assign wd_expire = (wdog == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wdog          <= '0;
      timeout_o     <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      if (wd_run) begin
        if (wd_expire) begin
          wdog      <= '0;
          timeout_o <= 1'b1;
          if (timeout_cnt_o != {CNT_W{1'b1}}) timeout_cnt_o <= timeout_cnt_o + 1'b1;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end else begin
        wdog <= '0;
      end
    end
  end
`else
  assign wd_expire     = 1'b0;
  assign timeout_o     = 1'b0;
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_irq_arbiter.sv
// Scoreboard bench for cv32e40p_irq_arbiter: expected grants queued at stimulus time, popped when irq_o raises a grant.
module tb_cv32e40p_irq_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] src_irq_i;
  logic        cfg_we_i;
  logic [31:0] cfg_en_i;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic [31:0] irq_o;
  logic [31:0] pending_o;
  logic [31:0] enable_o;
  logic        busy_o;
  logic        spurious_o;
  logic        timeout_o;
  logic [7:0]  timeout_cnt_o;

  cv32e40p_irq_arbiter dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .src_irq_i    (src_irq_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_en_i     (cfg_en_i),
    .irq_ack_i    (irq_ack_i),
    .irq_id_i     (irq_id_i),
    .irq_o        (irq_o),
    .pending_o    (pending_o),
    .enable_o     (enable_o),
    .busy_o       (busy_o),
    .spurious_o   (spurious_o),
    .timeout_o    (timeout_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] irq;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] prev_irq = 32'd0;
  int          g;
  int          t;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_grant(input int id, input int at);
    exp_t x;
    x.irq = 32'd1 << id;
    x.cyc = at;
    sb_q.push_back(x);
  endtask

  task automatic cfg_write(input logic [31:0] v);
    cfg_we_i = 1'b1;
    cfg_en_i = v;
    tick();
    cfg_we_i = 1'b0;
  endtask

  // New non-zero irq_o value marks a grant; match it against the oldest expected grant.
  always @(negedge clk_i) begin
    if (irq_o != 32'd0 && irq_o != prev_irq) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_grant", irq_o, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("grant_vec", irq_o, e.irq);
        check_val("grant_cycle", cyc, e.cyc);
        check_val("grant_busy", {31'd0, busy_o}, 32'd1);
      end
    end
    prev_irq = irq_o;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int order[4];
    order = '{20, 11, 3, 7};
    rst_n     = 1'b0;
    src_irq_i = 32'd0;
    cfg_we_i  = 1'b0;
    cfg_en_i  = 32'd0;
    irq_ack_i = 1'b0;
    irq_id_i  = 5'd0;
    tick(3);
    check_val("rst_irq", irq_o, 32'd0);
    check_val("rst_pending", pending_o, 32'd0);
    check_val("rst_enable", enable_o, 32'd0);
    check_val("rst_flags", {29'd0, busy_o, spurious_o, timeout_o}, 32'd0);
    check_val("rst_tcnt", {24'd0, timeout_cnt_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // basic grant and retire
    cfg_write(32'h0000_0800);
    t = cyc;
    src_irq_i = 32'h0000_0800;
    push_grant(11, t + 2);
    tick();
    src_irq_i = 32'd0;
    check_val("basic_pending", pending_o, 32'h0000_0800);
    check_val("basic_no_irq_yet", irq_o, 32'd0);
    tick(4);
    check_val("basic_hold", irq_o, 32'h0000_0800);
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd11;
    tick();
    irq_ack_i = 1'b0;
    check_val("basic_retire_irq", irq_o, 32'd0);
    check_val("basic_retire_pend", pending_o, 32'd0);
    check_val("basic_no_spurious", {31'd0, spurious_o}, 32'd0);

    // priority order 20, 11, 3, 7
    cfg_write(32'hFFFF_FFFF);
    check_val("enable_masked", enable_o, 32'hFFFF_0888);
    src_irq_i = 32'h0010_0888 | 32'h0000_0020;
    push_grant(20, cyc + 2);
    tick();
    src_irq_i = 32'd0;
    check_val("prio_pending", pending_o, 32'h0010_0888);
    tick();
    for (int k = 0; k < 4; k++) begin
      g = cyc;
      irq_ack_i = 1'b1;
      irq_id_i  = 5'(order[k]);
      if (k < 3) push_grant(order[k+1], g + 2);
      tick();
      irq_ack_i = 1'b0;
      check_val("prio_gap", irq_o, 32'd0);
      tick();
    end
    check_val("prio_drained", pending_o, 32'd0);

    // wrong-ID ack
    src_irq_i = 32'h0001_0000;
    push_grant(16, cyc + 2);
    tick();
    src_irq_i = 32'd0;
    tick();
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd17;
    tick();
    irq_ack_i = 1'b0;
    check_val("wrong_id_spur", {31'd0, spurious_o}, 32'd1);
    check_val("wrong_id_hold", irq_o, 32'h0001_0000);
    tick();
    check_val("wrong_id_spur_end", {31'd0, spurious_o}, 32'd0);
    check_val("wrong_id_hold2", irq_o, 32'h0001_0000);

    // set/clear collision on 16
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd16;
    src_irq_i = 32'h0001_0000;
    push_grant(16, cyc + 2);
    tick();
    irq_ack_i = 1'b0;
    src_irq_i = 32'd0;
    check_val("collide_pend", pending_o, 32'h0001_0000);
    check_val("collide_idle", irq_o, 32'd0);
    tick();
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd16;
    tick();
    irq_ack_i = 1'b0;
    check_val("collide_retire", pending_o, 32'd0);

    // ack while idle
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd3;
    tick();
    irq_ack_i = 1'b0;
    check_val("idle_ack_spur", {31'd0, spurious_o}, 32'd1);
    tick();

    // masking of illegal source, then enable withdrawal
    src_irq_i = 32'h0000_0020;
    tick();
    src_irq_i = 32'd0;
    check_val("illegal_src", pending_o, 32'd0);
    tick();
    check_val("illegal_no_irq", irq_o, 32'd0);
    src_irq_i = 32'h0010_0000;
    push_grant(20, cyc + 2);
    tick();
    src_irq_i = 32'd0;
    tick();
    cfg_write(32'hFFEF_FFFF);
    check_val("withdraw_enable", enable_o, 32'hFFEF_0888);
    check_val("withdraw_still", irq_o, 32'h0010_0000);
    tick();
    check_val("withdraw_irq", irq_o, 32'd0);
    check_val("withdraw_pend", pending_o, 32'h0010_0000);
    check_val("withdraw_busy", {31'd0, busy_o}, 32'd0);

    // watchdog on ID 17
    cfg_write(32'h0002_0000);
    src_irq_i = 32'h0002_0000;
    push_grant(17, cyc + 2);
    tick();
    src_irq_i = 32'd0;
    tick();
    g = cyc;
`ifdef CV32E40P_IRQ_TIMEOUT_EN
    push_grant(17, g + 66);
    tick(63);
    check_val("wd_pre_irq", irq_o, 32'h0002_0000);
    check_val("wd_pre_to", {31'd0, timeout_o}, 32'd0);
    tick();
    check_val("wd_to_pulse", {31'd0, timeout_o}, 32'd1);
    check_val("wd_to_cnt", {24'd0, timeout_cnt_o}, 32'd1);
    check_val("wd_to_irq", irq_o, 32'd0);
    check_val("wd_to_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check_val("wd_backoff_to", {31'd0, timeout_o}, 32'd0);
    check_val("wd_backoff_irq", irq_o, 32'd0);
    tick();
`else
    tick(70);
    check_val("nowd_hold", irq_o, 32'h0002_0000);
    check_val("nowd_to", {31'd0, timeout_o}, 32'd0);
    check_val("nowd_cnt", {24'd0, timeout_cnt_o}, 32'd0);
`endif

    // reset mid-ASSERT
    rst_n = 1'b0;
    tick();
    check_val("midrst_irq", irq_o, 32'd0);
    check_val("midrst_pend", pending_o, 32'd0);
    check_val("midrst_en", enable_o, 32'd0);
    check_val("midrst_flags", {29'd0, busy_o, spurious_o, timeout_o}, 32'd0);
    check_val("midrst_cnt", {24'd0, timeout_cnt_o}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    check_val("post_rst_irq", irq_o, 32'd0);
    check_val("sb_left", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
